// File: rtl/ads1115_scan_sequencer.sv
// ADS1115 single-shot scan sequencer: drives an I2C transaction engine round-robin over AIN0..AIN3.
// Build option ADS1115_ALERT_RDY_EN: threshold setup plus ALERT/RDY pin completion instead of OS polling.
module ads1115_scan_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h48,
  parameter logic [2:0]  PGA        = 3'b001,
  parameter logic [2:0]  DR         = 3'b100,
  parameter logic [3:0]  CH_MASK    = 4'b1111,
  parameter logic [15:0] POLL_LIMIT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
`ifdef ADS1115_ALERT_RDY_EN
  input  logic        alert_rdy_n,
`endif
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_addr,
  output logic        cmd_rw,
  output logic [7:0]  cmd_reg,
  output logic [15:0] cmd_wdata,
  output logic        cmd_only_register,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [15:0] i2c_rdata,
  output logic        sample_valid,
  output logic [1:0]  sample_ch,
  output logic [15:0] sample_data,
  output logic        busy,
  output logic        error,
  output logic [1:0]  error_code
);

  // state    | meaning
  // IDLE     | waiting for enable
  // SEL_CH   | choose next enabled channel
  // WR_HI    | write Hi_thresh = 0x8000 (alert build, first pass only)
  // WR_LO    | write Lo_thresh = 0x0000 (alert build, first pass only)
  // WR_CFG   | write config word, starts a single-shot conversion
  // PTR_CFG  | point at config register
  // RD_CFG   | read config, poll OS bit
  // WAIT_RDY | wait for ALERT/RDY falling edge (alert build)
  // PTR_CONV | point at conversion register
  // RD_CONV  | read conversion result
  // PUBLISH  | one-cycle sample_valid
  // ERROR    | sticky fault until enable drops
  typedef enum logic [3:0] {
    S_IDLE, S_SEL_CH, S_WR_HI, S_WR_LO, S_WR_CFG, S_PTR_CFG, S_RD_CFG,
    S_WAIT_RDY, S_PTR_CONV, S_RD_CONV, S_PUBLISH, S_ERROR
  } state_t;

`ifdef ADS1115_ALERT_RDY_EN
  localparam logic [4:0] CFG_TAIL = 5'b00000;
`else
  localparam logic [4:0] CFG_TAIL = 5'b00011;
`endif

  state_t      state_q, state_d;
  logic        pending_q, first_q, is_cmd, done;
  logic [1:0]  ch_q, ch_pick, err_q, err_d;
  logic [15:0] poll_q, data_q;

  // First set mask bit strictly after 'last', wrapping 3->0.
  function automatic logic [1:0] next_ch(input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] c;
    pick = last;
    for (int i = 4; i >= 1; i--) begin
      c = last + 2'(i);
      if (CH_MASK[c]) pick = c;
    end
    return pick;
  endfunction

  assign ch_pick = next_ch(first_q ? 2'd3 : ch_q);
  assign done    = pending_q & i2c_done;
  assign is_cmd  = state_q inside {S_WR_HI, S_WR_LO, S_WR_CFG, S_PTR_CFG, S_RD_CFG, S_PTR_CONV, S_RD_CONV};

`ifdef ADS1115_ALERT_RDY_EN
  logic [2:0] rdy_sync_q;
  logic       rdy_fall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_sync_q <= 3'b111;
    else        rdy_sync_q <= {rdy_sync_q[1:0], alert_rdy_n};
  end
  assign rdy_fall = rdy_sync_q[2] & ~rdy_sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:     if (enable && CH_MASK != 4'b0000) state_d = S_SEL_CH;
`ifdef ADS1115_ALERT_RDY_EN
      S_SEL_CH:   state_d = !enable ? S_IDLE : (first_q ? S_WR_HI : S_WR_CFG);
      S_WR_HI:    if (done) state_d = enable ? S_WR_LO : S_IDLE;
      S_WR_LO:    if (done) state_d = enable ? S_WR_CFG : S_IDLE;
      S_WR_CFG:   if (done) state_d = enable ? S_WAIT_RDY : S_IDLE;
      S_WAIT_RDY: begin
        if (!enable) state_d = S_IDLE;
        else if (rdy_fall) state_d = S_PTR_CONV;
        else if (poll_q >= POLL_LIMIT) begin
          state_d = S_ERROR;
          err_d   = 2'b10;
        end
      end
`else
      S_SEL_CH:   state_d = enable ? S_WR_CFG : S_IDLE;
      S_WR_CFG:   if (done) state_d = enable ? S_PTR_CFG : S_IDLE;
`endif
      S_PTR_CFG:  if (done) state_d = enable ? S_RD_CFG : S_IDLE;
      S_RD_CFG: begin
        if (done) begin
          if (!enable) state_d = S_IDLE;
          else if (i2c_rdata[15]) state_d = S_PTR_CONV;
          else if ({1'b0, poll_q} + 17'd1 >= {1'b0, POLL_LIMIT}) begin
            state_d = S_ERROR;
            err_d   = 2'b10;
          end
        end
      end
      S_PTR_CONV: if (done) state_d = enable ? S_RD_CONV : S_IDLE;
      S_RD_CONV:  if (done) state_d = S_PUBLISH;
      S_PUBLISH:  state_d = enable ? S_SEL_CH : S_IDLE;
      S_ERROR: begin
        if (!enable) begin
          state_d = S_IDLE;
          err_d   = 2'b00;
        end
      end
      default:    state_d = S_IDLE;
    endcase
    if (done && i2c_nack) begin
      state_d = S_ERROR;
      err_d   = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      first_q   <= 1'b1;
      ch_q      <= 2'd0;
      poll_q    <= 16'd0;
      data_q    <= 16'd0;
      err_q     <= 2'b00;
    end else begin
      err_q <= err_d;
      if (cmd_valid && cmd_ready) pending_q <= 1'b1;
      else if (i2c_done)          pending_q <= 1'b0;
      if (state_q == S_IDLE) first_q <= 1'b1;
      else if (state_q == S_SEL_CH) begin
        first_q <= 1'b0;
        ch_q    <= ch_pick;
      end
      // Poll counter lives only while waiting for conversion completion.
      if (state_d != S_RD_CFG && state_d != S_WAIT_RDY) poll_q <= 16'd0;
      else if ((state_q == S_RD_CFG && done) || state_q == S_WAIT_RDY) poll_q <= poll_q + 16'd1;
      if (state_q == S_RD_CONV && done && !i2c_nack) data_q <= i2c_rdata;
    end
  end

  always_comb begin
    cmd_valid         = is_cmd & ~pending_q;
    cmd_addr          = DEV_ADDR;
    cmd_rw            = 1'b0;
    cmd_reg           = 8'h00;
    cmd_wdata         = 16'h0000;
    cmd_only_register = 1'b0;
    case (state_q)
      S_WR_HI: begin
        cmd_reg   = 8'h03;
        cmd_wdata = 16'h8000;
      end
      S_WR_LO:  cmd_reg = 8'h02;
      S_WR_CFG: begin
        cmd_reg   = 8'h01;
        cmd_wdata = {2'b11, ch_q, PGA, 1'b1, DR, CFG_TAIL};
      end
      S_PTR_CFG: begin
        cmd_reg           = 8'h01;
        cmd_only_register = 1'b1;
      end
      S_RD_CFG: begin
        cmd_reg = 8'h01;
        cmd_rw  = 1'b1;
      end
      S_PTR_CONV: cmd_only_register = 1'b1;
      S_RD_CONV:  cmd_rw = 1'b1;
      default: ;
    endcase
    sample_valid = (state_q == S_PUBLISH);
    sample_ch    = ch_q;
    sample_data  = data_q;
    busy         = (state_q != S_IDLE);
    error        = (state_q == S_ERROR);
    error_code   = err_q;
  end

endmodule

// File: tb/tb_ads1115_scan_sequencer.sv
// Bench for ads1115_scan_sequencer: randomized I2C engine model plus a command-stream reference model.
`timescale 1ns/1ps
module tb_ads1115_scan_sequencer;
  localparam logic [6:0] ADDR  = 7'h48;
  localparam logic [3:0] MASK  = 4'b0101;
  localparam int         LIMIT = 4;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [6:0]  cmd_addr;
  logic        cmd_rw, cmd_only_register;
  logic [7:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        i2c_done = 1'b0, i2c_nack = 1'b0;
  logic [15:0] i2c_rdata = 16'h0000;
  logic        sample_valid, busy, error;
  logic [1:0]  sample_ch, error_code;
  logic [15:0] sample_data;
`ifdef ADS1115_ALERT_RDY_EN
  logic        alert_rdy_n = 1'b1;
`endif

  always #5 clk = ~clk;

  ads1115_scan_sequencer #(
    .DEV_ADDR(ADDR), .PGA(3'b001), .DR(3'b100), .CH_MASK(MASK), .POLL_LIMIT(16'(LIMIT))
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef ADS1115_ALERT_RDY_EN
    .alert_rdy_n(alert_rdy_n),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_only_register(cmd_only_register),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .busy(busy), .error(error), .error_code(error_code)
  );

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  rg;
    logic [15:0] wd;
    logic        only;
  } cmd_t;

  cmd_t        cmd_log[$];
  logic [17:0] sample_log[$];
  logic [15:0] conv_data[$];
  logic [15:0] os_script[$];
  int          eng_cnt = 0, nack_at = -1, cv_cycles = 0;
  int          n_tests = 0, n_fail = 0;
  cmd_t        eng_cmd;
  logic        pend_nack = 1'b0, pend_conv = 1'b0;
  logic [15:0] pend_rdata = 16'h0000;

  // I2C engine model: random ready, random 1..4 cycle latency, scripted config reads.
  always @(negedge clk) begin
    if (!rst_n) begin
      eng_cnt = 0; i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 16'h0000; cmd_ready = 1'b0;
    end else begin
      if (i2c_done) begin
        i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 16'h0000;
      end
      if (cmd_valid) cv_cycles++;
      if (eng_cnt > 0) begin
        cmd_ready = 1'b0;
        eng_cnt--;
        if (eng_cnt == 0) begin
          i2c_done = 1'b1; i2c_nack = pend_nack; i2c_rdata = pend_rdata;
          if (pend_conv && !pend_nack) conv_data.push_back(pend_rdata);
        end
      end else begin
        cmd_ready = ($urandom_range(0, 3) != 0);
        if (cmd_valid && cmd_ready) begin
          eng_cmd.addr = cmd_addr;
          eng_cmd.rw   = cmd_rw;
          eng_cmd.rg   = cmd_reg;
          eng_cmd.only = cmd_only_register;
          eng_cmd.wd   = (cmd_rw || cmd_only_register) ? 16'h0000 : cmd_wdata;
          cmd_log.push_back(eng_cmd);
          pend_nack = (cmd_log.size() - 1 == nack_at);
          pend_conv = cmd_rw && (cmd_reg == 8'h00);
          if (cmd_rw && cmd_reg == 8'h01)
            pend_rdata = (os_script.size() > 0) ? os_script.pop_front() : 16'h8383;
          else if (pend_conv)
            pend_rdata = 16'($urandom);
          else
            pend_rdata = 16'h0000;
          eng_cnt = int'($urandom_range(1, 4));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && sample_valid) sample_log.push_back({sample_ch, sample_data});
  end

  // Reference: step 0..4 of one conversion on channel ch.
  function automatic cmd_t exp_cmd(int ch, int step);
    cmd_t c;
    c = '0;
    c.addr = ADDR;
    case (step)
      0: begin c.rg = 8'h01; c.wd = 16'hC383 + 16'(ch * 4096); end
      1: begin c.rg = 8'h01; c.only = 1'b1; end
      2: begin c.rg = 8'h01; c.rw = 1'b1; end
      3: begin c.rg = 8'h00; c.only = 1'b1; end
      default: begin c.rg = 8'h00; c.rw = 1'b1; end
    endcase
    return c;
  endfunction

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    nack_at = -1;
    os_script.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmd_log.delete(); sample_log.delete(); conv_data.delete();
  endtask

  task automatic clear_logs();
    cmd_log.delete(); sample_log.delete(); conv_data.delete();
  endtask

  task automatic wait_idle(input string tag);
    bit got = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (!busy) begin got = 1; break; end
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL %s_idle: busy stuck at %b, want 0", tag, busy); end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    #3;
    n_tests++;
    if ({cmd_valid, cmd_rw, cmd_reg, cmd_wdata, cmd_only_register} !== 27'd0) begin
      n_fail++; $display("FAIL reset_cmd: got %b/%b/%h/%h/%b, want zeros", cmd_valid, cmd_rw, cmd_reg, cmd_wdata, cmd_only_register);
    end
    n_tests++;
    if (cmd_addr !== ADDR) begin n_fail++; $display("FAIL reset_addr: got %h, want %h", cmd_addr, ADDR); end
    n_tests++;
    if ({sample_valid, sample_ch, sample_data} !== 19'd0) begin
      n_fail++; $display("FAIL reset_sample: got %b/%0d/%h, want zeros", sample_valid, sample_ch, sample_data);
    end
    n_tests++;
    if ({busy, error, error_code} !== 4'd0) begin
      n_fail++; $display("FAIL reset_status: got busy=%b err=%b code=%b, want zeros", busy, error, error_code);
    end
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || cv_cycles !== 0) begin
      n_fail++; $display("FAIL reset_hold: busy=%b cmd_valid cycles=%0d, want 0/0", busy, cv_cycles);
    end
  endtask

  task automatic test_scan();
    int  chans[$];
    bit  got = 0;
    int  n;
    cmd_t e;
    for (int c = 0; c < 4; c++) if (MASK[c]) chans.push_back(c);
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (sample_log.size() >= 6) begin got = 1; break; end
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL scan_samples: got %0d samples, want 6", sample_log.size()); end
    enable = 1'b0;
    wait_idle("scan");
    n_tests++;
    if (sample_log.size() != conv_data.size()) begin
      n_fail++; $display("FAIL scan_sample_count: got %0d, want %0d", sample_log.size(), conv_data.size());
    end
    n = (sample_log.size() < conv_data.size()) ? sample_log.size() : conv_data.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (sample_log[i] !== {2'(chans[i % chans.size()]), conv_data[i]}) begin
        n_fail++; $display("FAIL scan_sample[%0d]: got ch%0d %h, want ch%0d %h", i, sample_log[i][17:16],
                           sample_log[i][15:0], chans[i % chans.size()], conv_data[i]);
      end
    end
    for (int i = 0; i < cmd_log.size(); i++) begin
      e = exp_cmd(chans[(i / 5) % chans.size()], i % 5);
      n_tests++;
      if (cmd_log[i] !== e) begin
        n_fail++; $display("FAIL scan_cmd[%0d]: got %h, want %h", i, cmd_log[i], e);
      end
    end
    n = cmd_log.size();
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (cmd_log.size() != n) begin n_fail++; $display("FAIL scan_after_idle: got %0d cmds, want %0d", cmd_log.size(), n); end
  endtask

  task automatic test_poll();
    cmd_t exp_q[$];
    int   n0;
    bit   got;
    do_reset();
    for (int it = 0; it < 3; it++) begin
      n0 = (it == 0) ? 3 : int'($urandom_range(0, 3));
      clear_logs();
      exp_q.delete();
      for (int z = 0; z < n0; z++) os_script.push_back(16'h0383);
      exp_q.push_back(exp_cmd(0, 0));
      exp_q.push_back(exp_cmd(0, 1));
      for (int z = 0; z <= n0; z++) exp_q.push_back(exp_cmd(0, 2));
      exp_q.push_back(exp_cmd(0, 3));
      exp_q.push_back(exp_cmd(0, 4));
      enable = 1'b1;
      got = 0;
      for (int k = 0; k < 500; k++) begin
        @(posedge clk); #1;
        if (sample_valid) begin got = 1; break; end
      end
      enable = 1'b0;
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL poll_sample_seen[%0d]: got none, want one", it); end
      wait_idle("poll");
      n_tests++;
      if (cmd_log.size() != exp_q.size()) begin
        n_fail++; $display("FAIL poll_cmd_count[%0d]: got %0d, want %0d", it, cmd_log.size(), exp_q.size());
      end
      for (int i = 0; i < cmd_log.size() && i < exp_q.size(); i++) begin
        n_tests++;
        if (cmd_log[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL poll_cmd[%0d][%0d]: got %h, want %h", it, i, cmd_log[i], exp_q[i]);
        end
      end
      n_tests++;
      if (sample_log.size() != 1 || conv_data.size() != 1) begin
        n_fail++; $display("FAIL poll_one_sample[%0d]: got %0d samples/%0d reads, want 1/1", it, sample_log.size(), conv_data.size());
      end else if (sample_log[0] !== {2'd0, conv_data[0]}) begin
        n_fail++; $display("FAIL poll_one_sample[%0d]: got %h, want %h", it, sample_log[0], {2'd0, conv_data[0]});
      end
    end
  endtask

  task automatic test_nack();
    bit got;
    int cv;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      nack_at = (it == 0) ? 0 : int'($urandom_range(0, 4));
      enable = 1'b1;
      got = 0;
      for (int k = 0; k < 300; k++) begin
        @(posedge clk); #1;
        if (error) begin got = 1; break; end
      end
      n_tests++;
      if (!got || error_code !== 2'b01) begin
        n_fail++; $display("FAIL nack_code[%0d]: got err=%b code=%b, want 1/01", it, error, error_code);
      end
      cv = cv_cycles;
      repeat (10) @(posedge clk);
      #1;
      n_tests++;
      if (cmd_log.size() != nack_at + 1 || cv_cycles != cv) begin
        n_fail++; $display("FAIL nack_stop[%0d]: got %0d cmds (+%0d valid cycles), want %0d (+0)", it, cmd_log.size(), cv_cycles - cv, nack_at + 1);
      end
      n_tests++;
      if ({busy, error, error_code} !== 4'b1101 || sample_log.size() != 0) begin
        n_fail++; $display("FAIL nack_hold[%0d]: got busy=%b err=%b code=%b samples=%0d, want 1/1/01/0", it, busy, error, error_code, sample_log.size());
      end
      enable = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({busy, error, error_code} !== 4'b0000) begin
        n_fail++; $display("FAIL nack_clear[%0d]: got busy=%b err=%b code=%b, want zeros", it, busy, error, error_code);
      end
    end
    nack_at = -1;
  endtask

  task automatic test_timeout();
    bit got = 0;
    int rd_cfg = 0;
    do_reset();
    for (int z = 0; z < 10; z++) os_script.push_back(16'(z) & 16'h7FFF);
    enable = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (error) begin got = 1; break; end
    end
    n_tests++;
    if (!got || error_code !== 2'b10) begin
      n_fail++; $display("FAIL timeout_code: got err=%b code=%b, want 1/10", error, error_code);
    end
    repeat (5) @(posedge clk);
    foreach (cmd_log[i]) if (cmd_log[i].rw && cmd_log[i].rg == 8'h01) rd_cfg++;
    n_tests++;
    if (rd_cfg != LIMIT || cmd_log.size() != LIMIT + 2) begin
      n_fail++; $display("FAIL timeout_reads: got %0d config reads / %0d cmds, want %0d / %0d", rd_cfg, cmd_log.size(), LIMIT, LIMIT + 2);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, error, error_code} !== 4'b0000) begin
      n_fail++; $display("FAIL timeout_clear: got busy=%b err=%b code=%b, want zeros", busy, error, error_code);
    end
    os_script.delete();
  endtask

  task automatic test_enable_drop();
    bit got = 0;
    int n, cv;
    do_reset();
    for (int z = 0; z < 3; z++) os_script.push_back(16'h0383);
    enable = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (eng_cnt > 0 && cmd_log.size() > 0 && cmd_log[$].rw && cmd_log[$].rg == 8'h01) begin got = 1; break; end
    end
    enable = 1'b0;
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL drop_reach_rdcfg: got %0d cmds, want a pending config read", cmd_log.size()); end
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (i2c_done) begin got = 1; break; end
    end
    n_tests++;
    if (!got || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_busy: got done_seen=%b busy=%b, want 1/0", got, busy);
    end
    n = cmd_log.size();
    cv = cv_cycles;
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (n != 3 || cmd_log.size() != n || cv_cycles != cv || sample_log.size() != 0) begin
      n_fail++; $display("FAIL drop_quiet: got %0d->%0d cmds, +%0d valid cycles, %0d samples, want 3->3, +0, 0",
                         n, cmd_log.size(), cv_cycles - cv, sample_log.size());
    end
    os_script.delete();
  endtask

  task automatic test_reset_abort();
    bit got = 0;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (eng_cnt > 0 && cmd_log.size() >= 2) begin got = 1; break; end
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!got || {busy, cmd_valid, sample_valid, error} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_abort: got reached=%b busy=%b valid=%b sample=%b err=%b, want 1/0/0/0/0", got, busy, cmd_valid, sample_valid, error);
    end
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_poll();
    test_nack();
    test_timeout();
    test_enable_drop();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
